// File: rtl/ahb_slave_mux.sv
// AHB return-path multiplexor.
// Registers the address-phase HSEL as the data-phase select and routes the
// selected slave's HRDATA/HREADYOUT/HRESP back to the master. A built-in
// default slave answers active transfers that decode to no slave with the
// two-cycle ERROR response. HREADY from this block is the bus-wide HREADY.
module ahb_slave_mux #(
  parameter int DATA_WIDTH   = 32,
  parameter int NO_OF_SLAVES = 2
) (
  input  logic                               HCLK,
  input  logic                               HRESETn,
  input  logic [NO_OF_SLAVES-1:0]            HSEL,
  input  logic [1:0]                         HTRANS,
  input  logic [NO_OF_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
  input  logic [NO_OF_SLAVES-1:0]            HREADYOUT_S,
  input  logic [NO_OF_SLAVES-1:0]            HRESP_S,
  output logic [DATA_WIDTH-1:0]              HRDATA,
  output logic                               HREADY,
  output logic                               HRESP
);

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  ds_state_t                ds_state_q, ds_state_d;
  logic [NO_OF_SLAVES-1:0]  sel_q, sel_d;
  logic                     ds_hready_q, ds_hready_d;
  logic                     ds_hresp_q, ds_hresp_d;

  logic                     unmapped_act;
  logic                     hit;
  logic [DATA_WIDTH-1:0]    mux_rdata;
  logic                     mux_ready;
  logic                     mux_resp;

  // Only HTRANS[1] distinguishes active (NONSEQ/SEQ) from IDLE/BUSY.
  logic unused_htrans0;
  assign unused_htrans0 = HTRANS[0];

  // Active transfer that no slave claims.
  always_comb begin
    unmapped_act = (HSEL == '0) && HTRANS[1];
  end

  // Select capture: a new address phase is accepted only while the bus is ready.
  always_comb begin
    sel_d = HREADY ? HSEL : sel_q;
  end

  // Default-slave next state; its outputs are precomputed from the next state
  // so they come straight from flops.
  always_comb begin
    ds_state_d = ds_state_q;
    case (ds_state_q)
      DS_IDLE: if (HREADY && unmapped_act) ds_state_d = DS_ERR1;
      DS_ERR1: ds_state_d = DS_ERR2;
      // Second error cycle is a ready cycle, so the next address is sampled here.
      DS_ERR2: ds_state_d = unmapped_act ? DS_ERR1 : DS_IDLE;
      default: ds_state_d = DS_IDLE;
    endcase
    ds_hready_d = (ds_state_d != DS_ERR1);
    ds_hresp_d  = (ds_state_d != DS_IDLE);
  end

  // State registers, aborted immediately by reset.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_q       <= '0;
      ds_state_q  <= DS_IDLE;
      ds_hready_q <= 1'b1;
      ds_hresp_q  <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      ds_state_q  <= ds_state_d;
      ds_hready_q <= ds_hready_d;
      ds_hresp_q  <= ds_hresp_d;
    end
  end

  // Slave mux: scan from the top down so the lowest set select bit wins,
  // giving a deterministic result even for an illegal multi-hot select.
  always_comb begin
    hit       = 1'b0;
    mux_rdata = '0;
    mux_ready = 1'b1;
    mux_resp  = 1'b0;
    for (int i = NO_OF_SLAVES - 1; i >= 0; i--) begin
      if (sel_q[i]) begin
        hit       = 1'b1;
        mux_rdata = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
        mux_ready = HREADYOUT_S[i];
        mux_resp  = HRESP_S[i];
      end
    end
  end

  // Master-facing outputs: selected slave, otherwise the default slave.
  always_comb begin
    if (hit) begin
      HRDATA = mux_rdata;
      HREADY = mux_ready;
      HRESP  = mux_resp;
    end else begin
      HRDATA = '0;
      HREADY = ds_hready_q;
      HRESP  = ds_hresp_q;
    end
  end

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Testbench for ahb_slave_mux: directed vectors with literal expectations,
// plus a transaction-level model checked against the DUT every cycle.
module tb_ahb_slave_mux;

  localparam int DW = 32;
  localparam int NS = 2;

  logic             HCLK;
  logic             HRESETn;
  logic [NS-1:0]    HSEL;
  logic [1:0]       HTRANS;
  logic [NS*DW-1:0] HRDATA_S;
  logic [NS-1:0]    HREADYOUT_S;
  logic [NS-1:0]    HRESP_S;
  logic [DW-1:0]    HRDATA;
  logic             HREADY;
  logic             HRESP;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  ahb_slave_mux #(.DATA_WIDTH(DW), .NO_OF_SLAVES(NS)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HSEL        (HSEL),
    .HTRANS      (HTRANS),
    .HRDATA_S    (HRDATA_S),
    .HREADYOUT_S (HREADYOUT_S),
    .HRESP_S     (HRESP_S),
    .HRDATA      (HRDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // ---------------- transaction-level model ----------------
  // m_slave: index of the slave owning the data phase, -1 for none.
  // m_err_left: error cycles still owed by the default slave (2, 1 or 0).
  int m_slave    = -1;
  int m_err_left = 0;

  function automatic int lowest(input logic [NS-1:0] s);
    for (int i = 0; i < NS; i++) if (s[i]) return i;
    return -1;
  endfunction

  function automatic logic m_ready();
    if (m_slave >= 0) return HREADYOUT_S[m_slave];
    return (m_err_left != 2);
  endfunction

  function automatic logic m_resp();
    if (m_slave >= 0) return HRESP_S[m_slave];
    return (m_err_left != 0);
  endfunction

  function automatic logic [DW-1:0] m_rdata();
    if (m_slave >= 0) return HRDATA_S[m_slave*DW +: DW];
    return '0;
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m_slave    = -1;
      m_err_left = 0;
    end else if (m_err_left == 2) begin
      m_err_left = 1;
    end else if (m_ready()) begin
      m_slave    = lowest(HSEL);
      m_err_left = (HSEL == '0 && HTRANS[1]) ? 2 : 0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge HCLK) begin
    if (chk_en) begin
      checks++;
      if (HREADY !== m_ready() || HRESP !== m_resp() || HRDATA !== m_rdata()) begin
        errors++;
        $display("FAIL model t=%0t got rdy=%b resp=%b data=%h want rdy=%b resp=%b data=%h",
                 $time, HREADY, HRESP, HRDATA, m_ready(), m_resp(), m_rdata());
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic [1:0] hsel, input logic [1:0] trans,
                       input logic [1:0] rdy, input logic [1:0] resp,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    @(posedge HCLK);
    #1;
    HSEL        = hsel;
    HTRANS      = trans;
    HREADYOUT_S = rdy;
    HRESP_S     = resp;
    HRDATA_S    = {d1, d0};
  endtask

  task automatic lit(input string name, input logic rdy, input logic resp,
                     input logic [DW-1:0] data);
    #1;
    checks++;
    if (HREADY !== rdy || HRESP !== resp || HRDATA !== data) begin
      errors++;
      $display("FAIL %s got rdy=%b resp=%b data=%h want rdy=%b resp=%b data=%h",
               name, HREADY, HRESP, HRDATA, rdy, resp, data);
    end else begin
      $display("check %s rdy=%b resp=%b data=%h", name, HREADY, HRESP, HRDATA);
    end
  endtask

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [DW-1:0] Z = '0;

  initial begin
    HRESETn     = 1'b0;
    HSEL        = '0;
    HTRANS      = IDLE;
    HREADYOUT_S = '1;
    HRESP_S     = '0;
    HRDATA_S    = '0;

    drive(2'b00, IDLE, 2'b11, 2'b00, Z, Z);
    lit("reset_state", 1'b1, 1'b0, Z);
    drive(2'b00, IDLE, 2'b11, 2'b00, Z, Z);
    HRESETn = 1'b1;
    chk_en  = 1'b1;
    lit("post_reset_idle", 1'b1, 1'b0, Z);

    // Unmapped NONSEQ: ERR1, ERR2, then OKAY
    drive(2'b00, NSEQ, 2'b11, 2'b00, Z, Z);
    lit("unmapped_addr", 1'b1, 1'b0, Z);
    drive(2'b00, IDLE, 2'b11, 2'b00, Z, Z);
    lit("unmapped_err1", 1'b0, 1'b1, Z);
    drive(2'b00, IDLE, 2'b11, 2'b00, Z, Z);
    lit("unmapped_err2", 1'b1, 1'b1, Z);
    drive(2'b00, IDLE, 2'b11, 2'b00, Z, Z);
    lit("unmapped_okay", 1'b1, 1'b0, Z);

    // Back-to-back unmapped: SEQ sampled in ERR2 gives a second pair
    drive(2'b00, NSEQ, 2'b11, 2'b00, Z, Z);
    drive(2'b00, SEQ, 2'b11, 2'b00, Z, Z);
    lit("b2b_err1a", 1'b0, 1'b1, Z);
    drive(2'b00, SEQ, 2'b11, 2'b00, Z, Z);
    lit("b2b_err2a", 1'b1, 1'b1, Z);
    drive(2'b00, IDLE, 2'b11, 2'b00, Z, Z);
    lit("b2b_err1b", 1'b0, 1'b1, Z);
    drive(2'b00, IDLE, 2'b11, 2'b00, Z, Z);
    lit("b2b_err2b", 1'b1, 1'b1, Z);
    drive(2'b00, IDLE, 2'b11, 2'b00, Z, Z);
    lit("b2b_okay", 1'b1, 1'b0, Z);

    // Reset asserted in the middle of ERR1
    drive(2'b00, NSEQ, 2'b11, 2'b00, Z, Z);
    drive(2'b00, IDLE, 2'b11, 2'b00, Z, Z);
    lit("pre_reset_err1", 1'b0, 1'b1, Z);
    HRESETn = 1'b0;
    lit("reset_mid_err1", 1'b1, 1'b0, Z);
    drive(2'b00, IDLE, 2'b11, 2'b00, Z, Z);
    HRESETn = 1'b1;
    lit("after_reset_idle", 1'b1, 1'b0, Z);

    // Slave 1 read with two wait states; HSEL toggling during the wait ignored
    drive(2'b10, NSEQ, 2'b11, 2'b00, Z, 32'hDEADBEEF);
    lit("s1_addr", 1'b1, 1'b0, Z);
    drive(2'b01, NSEQ, 2'b01, 2'b00, 32'h0BADF00D, 32'hDEADBEEF);
    lit("s1_wait1", 1'b0, 1'b0, 32'hDEADBEEF);
    drive(2'b11, NSEQ, 2'b01, 2'b00, 32'h0BADF00D, 32'hDEADBEEF);
    lit("s1_wait2", 1'b0, 1'b0, 32'hDEADBEEF);
    drive(2'b00, IDLE, 2'b11, 2'b00, 32'h0BADF00D, 32'hDEADBEEF);
    lit("s1_data", 1'b1, 1'b0, 32'hDEADBEEF);
    drive(2'b00, IDLE, 2'b11, 2'b00, 32'h0BADF00D, 32'hDEADBEEF);
    lit("s1_done", 1'b1, 1'b0, Z);

    // Pipelined back-to-back reads from slave 0 then slave 1
    drive(2'b01, NSEQ, 2'b11, 2'b00, 32'h11111111, 32'h22222222);
    drive(2'b10, NSEQ, 2'b11, 2'b00, 32'h11111111, 32'h22222222);
    lit("pipe_s0", 1'b1, 1'b0, 32'h11111111);
    drive(2'b00, IDLE, 2'b11, 2'b00, 32'h11111111, 32'h22222222);
    lit("pipe_s1", 1'b1, 1'b0, 32'h22222222);
    drive(2'b00, IDLE, 2'b11, 2'b00, 32'h11111111, 32'h22222222);
    lit("pipe_end", 1'b1, 1'b0, Z);

    // Unmapped IDLE and BUSY give zero-wait OKAY
    drive(2'b00, BUSY, 2'b11, 2'b00, Z, Z);
    lit("busy_a", 1'b1, 1'b0, Z);
    drive(2'b00, BUSY, 2'b11, 2'b00, Z, Z);
    lit("busy_b", 1'b1, 1'b0, Z);
    drive(2'b00, IDLE, 2'b11, 2'b00, Z, Z);
    lit("busy_c", 1'b1, 1'b0, Z);

    // Slave 0 ERROR passes through unmodified; ignored once deselected
    drive(2'b01, NSEQ, 2'b11, 2'b00, 32'h5A5A5A5A, Z);
    drive(2'b00, IDLE, 2'b10, 2'b01, 32'h5A5A5A5A, Z);
    lit("s0_err_cycle1", 1'b0, 1'b1, 32'h5A5A5A5A);
    drive(2'b00, IDLE, 2'b11, 2'b01, 32'h5A5A5A5A, Z);
    lit("s0_err_cycle2", 1'b1, 1'b1, 32'h5A5A5A5A);
    drive(2'b00, IDLE, 2'b11, 2'b01, 32'h5A5A5A5A, Z);
    lit("s0_deselected", 1'b1, 1'b0, Z);

    // Illegal multi-hot select resolves to the lowest index
    drive(2'b11, NSEQ, 2'b11, 2'b00, 32'hAAAA0000, 32'hBBBB0000);
    drive(2'b00, IDLE, 2'b10, 2'b00, 32'hAAAA0000, 32'hBBBB0000);
    lit("multihot_low", 1'b0, 1'b0, 32'hAAAA0000);
    drive(2'b00, IDLE, 2'b11, 2'b00, 32'hAAAA0000, 32'hBBBB0000);
    lit("multihot_done", 1'b1, 1'b0, 32'hAAAA0000);

    drive(2'b00, IDLE, 2'b11, 2'b00, Z, Z);
    drive(2'b00, IDLE, 2'b11, 2'b00, Z, Z);
    @(posedge HCLK);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_slave_mux.md
Name: ahb_slave_mux

Overview:
- Return-path multiplexor for the AHB fabric, the complement of the address decoder.
- Captures the decoder's address-phase HSEL into a data-phase select register. Routes the selected slave's HRDATA/HREADYOUT/HRESP back to the master.
- Contains a built-in default slave that gives the AHB two-cycle ERROR response to active transfers that decode to no slave.
- Sits between the slave array and the single master; its HREADY output is the bus-wide HREADY.

Parameters:
DATA_WIDTH, 32, width of HRDATA per slave and at the master
NO_OF_SLAVES, 2, number of slave ports; must equal the decoder's NO_OF_SLAVES

Ports:
HCLK  input  1  bus clock, all state on rising edge
HRESETn  input  1  asynchronous active-low reset
HSEL  input  NO_OF_SLAVES  address-phase one-hot select from decoder; all-zero = unmapped
HTRANS  input  2  master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
HRDATA_S  input  NO_OF_SLAVES*DATA_WIDTH  slave read data, slave i at bits [i*DATA_WIDTH +: DATA_WIDTH]
HREADYOUT_S  input  NO_OF_SLAVES  per-slave ready
HRESP_S  input  NO_OF_SLAVES  per-slave response (0 OKAY, 1 ERROR)
HRDATA  output  DATA_WIDTH  read data to master
HREADY  output  1  bus ready to master and all slaves
HRESP  output  1  response to master

Behaviour:
- Registers:
  - sel_q[NO_OF_SLAVES-1:0]: data-phase select.
  - ds_state: default-slave FSM state, encoded {DS_IDLE, DS_ERR1, DS_ERR2}.
- Reset, asynchronous on HRESETn low:
  - sel_q=0, ds_state=DS_IDLE.
  - Outputs then resolve to HREADY=1, HRESP=0, HRDATA=0.
  - Reset mid-transfer (including during DS_ERR1/DS_ERR2) aborts immediately to this state.
- Address-phase capture, at each HCLK rising edge while HREADY (own output) = 1:
  - sel_q <= HSEL.
  - unmapped_act = (HSEL==0) && HTRANS[1].
  - While HREADY=0, sel_q and the captured request hold. HSEL/HTRANS changes are ignored.
- Default-slave FSM:
  - DS_IDLE: outputs HREADY=1, HRESP=0. If HREADY=1 and unmapped_act, next state is DS_ERR1.
  - DS_ERR1: outputs HREADY=0, HRESP=1. Always goes to DS_ERR2 next.
  - DS_ERR2: outputs HREADY=1, HRESP=1. Address is sampled this cycle. Goes to DS_ERR1 if unmapped_act, otherwise DS_IDLE.
  - Unmapped IDLE/BUSY: sel_q=0, ds_state stays DS_IDLE, giving a zero-wait OKAY.
- Output mux (combinational from registered state):
  - sel_q != 0: lowest set index i wins. HRDATA=HRDATA_S[i], HREADY=HREADYOUT_S[i], HRESP=HRESP_S[i].
  - sel_q == 0: HRDATA=0, and HREADY/HRESP come from the default-slave FSM.
  - ds_state is non-IDLE only when sel_q==0. Transition into DS_ERR1 and the sel_q<=0 capture happen on the same edge.
- Latency: zero added cycles. Slave responses reach the master combinationally in the same cycle. The select is valid one cycle after address acceptance.
- Multi-hot HSEL is illegal from the decoder. The mux resolves it deterministically via the lowest-index rule. No assertion output.
- Slave-originated ERROR is passed through untouched; the mux does not sequence slave two-cycle errors.
- Master cancelling after an ERROR (driving IDLE in the second error cycle) needs no special handling: it is captured as a normal address phase.
- Target RTL: ~150–250 lines, synthesizable, no latches, parameterized mux loop.

Test Plan:
- Reset: assert HRESETn=0 mid DS_ERR1 -> outputs immediately HREADY=1, HRESP=0, HRDATA=0. After release, an IDLE cycle keeps these values.
- Slave-1 read with wait: HSEL=2'b10, HTRANS=NONSEQ. Data phase: HREADYOUT_S[1]=0 for 2 cycles, then 1 with HRDATA_S[1]=32'hDEADBEEF -> HREADY low for 2 cycles, then HRDATA=32'hDEADBEEF, HRESP=0. HSEL toggled during the wait is ignored.
- Pipelined back-to-back: NONSEQ to slave0 then slave1 on consecutive cycles, slaves zero-wait with data 32'h11111111/32'h22222222 -> HRDATA shows 32'h11111111 then 32'h22222222 on consecutive cycles.
- Unmapped NONSEQ: HSEL=0, HTRANS=2'b10 -> next cycle HREADY=0/HRESP=1, following cycle HREADY=1/HRESP=1, then OKAY. Back-to-back unmapped SEQ sampled in DS_ERR2 -> a second ERR1/ERR2 pair with no gap.
- Unmapped IDLE/BUSY: HSEL=0, HTRANS=00 and 01 -> HREADY=1, HRESP=0, HRDATA=0 every cycle, FSM stays DS_IDLE.
- Slave ERROR pass-through: slave0 drives HRESP_S[0]=1 with HREADYOUT_S[0]=0 then 1 -> HRESP/HREADY mirror those values exactly with no added cycles.
